// File: rtl/qupls_preg_release_queue_if.sv
// Commit/flush side bundle between the committer and the physical register release queue.
// The master drives commits and flushes; the slave (queue) returns release slots and status.
interface qupls_preg_release_queue_if #(
    parameter int unsigned PREGS   = 192,
    parameter int unsigned PREG_W  = 8,
    parameter int unsigned NCOMMIT = 4,
    parameter int unsigned NFTAGS  = 4,
    parameter int unsigned QDEPTH  = 16
);
    logic [NCOMMIT-1:0]        cmt_v;
    logic [NCOMMIT*PREG_W-1:0] cmt_tag;
    logic                      cmt_rdy;
    logic                      flush_v;
    logic [PREGS-1:0]          flush_list;
    logic [NFTAGS*PREG_W-1:0]  tags2free;
    logic [NFTAGS-1:0]         freevals;
    logic [PREGS-1:0]          list2free;
    logic [$clog2(QDEPTH):0]   count;
    logic                      ovf;

    modport master (
        output cmt_v, cmt_tag, flush_v, flush_list,
        input  cmt_rdy, tags2free, freevals, list2free, count, ovf
    );

    modport slave (
        input  cmt_v, cmt_tag, flush_v, flush_list,
        output cmt_rdy, tags2free, freevals, list2free, count, ovf
    );
endinterface

// File: rtl/qupls_preg_release_queue.sv
// Circular queue of displaced physical register tags: compacts committing lanes in,
// drains up to NFTAGS per clock to the renamer, and registers the flush bitmap.
module qupls_preg_release_queue #(
    parameter int unsigned PREGS   = 192,
    parameter int unsigned PREG_W  = 8,
    parameter int unsigned NCOMMIT = 4,
    parameter int unsigned NFTAGS  = 4,
    parameter int unsigned QDEPTH  = 16
) (
    input logic                     clk,
    input logic                     rst,
    qupls_preg_release_queue_if.slave rq
);
    localparam int unsigned PW = $clog2(QDEPTH);
    localparam int unsigned CW = PW + 1;

    logic [PREG_W-1:0]        q [QDEPTH];
    logic [PW-1:0]            wr_ptr;
    logic [PW-1:0]            rd_ptr;
    logic [CW-1:0]            count_r;
    logic [NFTAGS*PREG_W-1:0] tags2free_r;
    logic [NFTAGS-1:0]        freevals_r;
    logic [PREGS-1:0]         list2free_r;
    logic                     ovf_r;

    logic                     cmt_rdy;
    logic                     refuse;
    logic [PREG_W-1:0]        lane_tag [NCOMMIT];
    logic [NCOMMIT-1:0]       lane_wr;
    logic [PW-1:0]            lane_idx [NCOMMIT];
    logic [CW-1:0]            acc_cnt;
    logic [CW-1:0]            drain_cnt;
    logic [NFTAGS*PREG_W-1:0] tags2free_nxt;
    logic [NFTAGS-1:0]        freevals_nxt;

    // Readiness depends only on the registered count so it never loops back through cmt_v.
    assign cmt_rdy = (CW'(QDEPTH) - count_r) >= CW'(NCOMMIT);
    assign refuse  = !cmt_rdy && (|rq.cmt_v);

    // Each accepted lane lands at wr_ptr plus the number of accepted lanes before it.
    always_comb begin
        acc_cnt  = '0;
        lane_wr  = '0;
        lane_tag = '{default: '0};
        lane_idx = '{default: '0};
        for (int unsigned i = 0; i < NCOMMIT; i++) begin
            lane_tag[i] = rq.cmt_tag[i*PREG_W +: PREG_W];
            lane_idx[i] = wr_ptr + PW'(acc_cnt);
            lane_wr[i]  = cmt_rdy && rq.cmt_v[i] && (lane_tag[i] != '0);
            if (lane_wr[i]) begin
                acc_cnt = acc_cnt + CW'(1);
            end
        end
    end

    always_comb begin
        drain_cnt     = (count_r > CW'(NFTAGS)) ? CW'(NFTAGS) : count_r;
        tags2free_nxt = '0;
        freevals_nxt  = '0;
        for (int unsigned j = 0; j < NFTAGS; j++) begin
            if (CW'(j) < drain_cnt) begin
                tags2free_nxt[j*PREG_W +: PREG_W] = q[rd_ptr + PW'(j)];
                freevals_nxt[j]                   = 1'b1;
            end
        end
    end

    // Storage is not reset: only occupied entries are ever read.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NCOMMIT; i++) begin
            if (lane_wr[i]) begin
                q[lane_idx[i]] <= lane_tag[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_r     <= '0;
            tags2free_r <= '0;
            freevals_r  <= '0;
            list2free_r <= '0;
            ovf_r       <= 1'b0;
        end else begin
            wr_ptr      <= wr_ptr + PW'(acc_cnt);
            rd_ptr      <= rd_ptr + PW'(drain_cnt);
            count_r     <= count_r + acc_cnt - drain_cnt;
            tags2free_r <= tags2free_nxt;
            freevals_r  <= freevals_nxt;
            list2free_r <= rq.flush_v ? rq.flush_list : '0;
            if (refuse) begin
                ovf_r <= 1'b1;
            end
        end
    end

    assign rq.cmt_rdy   = cmt_rdy;
    assign rq.tags2free = tags2free_r;
    assign rq.freevals  = freevals_r;
    assign rq.list2free = list2free_r;
    assign rq.count     = count_r;
    assign rq.ovf       = ovf_r;
endmodule

// File: tb/tb_qupls_preg_release_queue.sv
// Bench for the physical register release queue: a FIFO reference model checks a default
// instance and a single-drain instance that can actually fill and backpressure.
module tb_qupls_preg_release_queue;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    qupls_preg_release_queue_if #(.PREGS(192), .PREG_W(8), .NCOMMIT(4), .NFTAGS(4), .QDEPTH(16)) rq ();
    qupls_preg_release_queue_if #(.PREGS(192), .PREG_W(8), .NCOMMIT(4), .NFTAGS(1), .QDEPTH(8))  rs ();

    qupls_preg_release_queue #(.PREGS(192), .PREG_W(8), .NCOMMIT(4), .NFTAGS(4), .QDEPTH(16)) dut (
        .clk(clk), .rst(rst), .rq(rq.slave)
    );
    qupls_preg_release_queue #(.PREGS(192), .PREG_W(8), .NCOMMIT(4), .NFTAGS(1), .QDEPTH(8)) dut_s (
        .clk(clk), .rst(rst), .rq(rs.slave)
    );

    int checks = 0;
    int passed = 0;

    // stimulus for the next edge
    logic [3:0]   m_v, s_v;
    logic [31:0]  m_tags, s_tags;
    logic         m_fv;
    logic [191:0] m_fl;

    // reference model: plain FIFOs of tags
    int           mq[$];
    int           sq[$];
    bit           m_ovf, s_ovf;
    logic [31:0]  e_t2f;
    logic [3:0]   e_fv;
    logic [191:0] e_list;
    logic [7:0]   e_s_t2f;
    logic         e_s_fv;
    logic [7:0]   rel[$];

    task automatic drive_idle();
        m_v = '0; m_tags = '0; m_fv = 1'b0; m_fl = '0; s_v = '0; s_tags = '0;
        rq.cmt_v = '0; rq.cmt_tag = '0; rq.flush_v = 1'b0; rq.flush_list = '0;
        rs.cmt_v = '0; rs.cmt_tag = '0; rs.flush_v = 1'b0; rs.flush_list = '0;
    endtask

    // One clock edge: apply stimulus, advance both models, land 1 time unit after the edge.
    task automatic tick();
        int  d;
        bit  rdy;
        rq.cmt_v = m_v; rq.cmt_tag = m_tags; rq.flush_v = m_fv; rq.flush_list = m_fl;
        rs.cmt_v = s_v; rs.cmt_tag = s_tags;
        @(posedge clk);
        rdy   = (16 - mq.size()) >= 4;
        d     = (mq.size() < 4) ? mq.size() : 4;
        e_t2f = '0;
        e_fv  = '0;
        for (int j = 0; j < d; j++) begin
            e_t2f[j*8 +: 8] = 8'(mq.pop_front());
            e_fv[j] = 1'b1;
        end
        if (rdy) begin
            for (int i = 0; i < 4; i++)
                if (m_v[i] && m_tags[i*8 +: 8] != 8'd0) mq.push_back(int'(m_tags[i*8 +: 8]));
        end else if (|m_v) m_ovf = 1'b1;
        e_list = m_fv ? m_fl : '0;

        rdy     = (8 - sq.size()) >= 4;
        e_s_fv  = sq.size() > 0;
        e_s_t2f = e_s_fv ? 8'(sq.pop_front()) : 8'd0;
        if (rdy) begin
            for (int i = 0; i < 4; i++)
                if (s_v[i] && s_tags[i*8 +: 8] != 8'd0) sq.push_back(int'(s_tags[i*8 +: 8]));
        end else if (|s_v) s_ovf = 1'b1;
        #1;
        drive_idle();
    endtask

    task automatic rst_assert();
        #3 rst = 1'b1;
        mq.delete(); sq.delete();
        m_ovf = 1'b0; s_ovf = 1'b0;
        e_t2f = '0; e_fv = '0; e_list = '0; e_s_t2f = '0; e_s_fv = 1'b0;
        #1;
    endtask

    task automatic rst_release();
        @(posedge clk);
        #2 rst = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (rq.count !== 5'd0) $display("FAIL reset_count: got %0d exp 0", rq.count); else passed++;
        checks++; if (rq.cmt_rdy !== 1'b1) $display("FAIL reset_rdy: got %b exp 1", rq.cmt_rdy); else passed++;
        checks++; if (rq.freevals !== 4'd0) $display("FAIL reset_fv: got %b exp 0", rq.freevals); else passed++;
        #10 rst = 1'b0;
        m_v = 4'hf; m_tags = 32'h0403_0201; m_fv = 1'b1; m_fl = '1;
        tick();
        m_v = 4'hf; m_tags = 32'h0807_0605;
        tick();
        checks++; if (rq.freevals !== 4'hf) $display("FAIL reset_pre_fv: got %b exp 1111", rq.freevals); else passed++;
        rst_assert();
        checks++; if (rq.count !== 5'd0) $display("FAIL reset_async_count: got %0d exp 0", rq.count); else passed++;
        checks++; if (rq.cmt_rdy !== 1'b1) $display("FAIL reset_async_rdy: got %b exp 1", rq.cmt_rdy); else passed++;
        checks++; if (rq.freevals !== 4'd0) $display("FAIL reset_async_fv: got %b exp 0", rq.freevals); else passed++;
        checks++; if (rq.tags2free !== 32'd0) $display("FAIL reset_async_t2f: got %h exp 0", rq.tags2free); else passed++;
        checks++; if (rq.list2free !== 192'd0) $display("FAIL reset_async_list: got %h exp 0", rq.list2free); else passed++;
        checks++; if (rq.ovf !== 1'b0) $display("FAIL reset_async_ovf: got %b exp 0", rq.ovf); else passed++;
        rst_release();
    endtask

    task automatic test_compaction();
        m_v = 4'b1010; m_tags = 32'h4399_2199;
        tick();
        checks++; if (rq.count !== 5'd2) $display("FAIL compact_count: got %0d exp 2", rq.count); else passed++;
        tick();
        checks++; if (rq.tags2free !== 32'h0000_4321) $display("FAIL compact_t2f: got %h exp 00004321", rq.tags2free); else passed++;
        checks++; if (rq.freevals !== 4'b0011) $display("FAIL compact_fv: got %b exp 0011", rq.freevals); else passed++;
        m_v = 4'b1111; m_tags = 32'h0700_0500;
        tick();
        tick();
        checks++; if (rq.tags2free !== 32'h0000_0705) $display("FAIL compact_zero_t2f: got %h exp 00000705", rq.tags2free); else passed++;
        checks++; if (rq.freevals !== 4'b0011) $display("FAIL compact_zero_fv: got %b exp 0011", rq.freevals); else passed++;
        tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 150; n++) begin
            m_v = 4'($urandom);
            for (int i = 0; i < 4; i++) m_tags[i*8 +: 8] = 8'($urandom_range(0, 191));
            m_fv = ($urandom_range(0, 7) == 0);
            for (int k = 0; k < 6; k++) m_fl[k*32 +: 32] = $urandom;
            tick();
            checks++; if (rq.tags2free !== e_t2f) $display("FAIL rand_t2f[%0d]: got %h exp %h", n, rq.tags2free, e_t2f); else passed++;
            checks++; if (rq.freevals !== e_fv) $display("FAIL rand_fv[%0d]: got %b exp %b", n, rq.freevals, e_fv); else passed++;
            checks++; if (rq.count !== 5'(mq.size())) $display("FAIL rand_count[%0d]: got %0d exp %0d", n, rq.count, mq.size()); else passed++;
            checks++; if (rq.cmt_rdy !== ((16 - mq.size()) >= 4)) $display("FAIL rand_rdy[%0d]: got %b", n, rq.cmt_rdy); else passed++;
            checks++; if (rq.list2free !== e_list) $display("FAIL rand_list[%0d]: got %h exp %h", n, rq.list2free, e_list); else passed++;
            checks++; if (rq.ovf !== m_ovf) $display("FAIL rand_ovf[%0d]: got %b exp %b", n, rq.ovf, m_ovf); else passed++;
        end
        tick(); tick();
    endtask

    task automatic test_wrap();
        int bad;
        rel.delete();
        for (int n = 0; n < 43; n++) begin
            if (n < 40) begin
                m_v = 4'hf;
                for (int i = 0; i < 4; i++) m_tags[i*8 +: 8] = 8'(4*n + i + 1);
            end
            tick();
            for (int j = 0; j < 4; j++) if (rq.freevals[j]) rel.push_back(rq.tags2free[j*8 +: 8]);
            checks++; if (rq.tags2free !== e_t2f || rq.freevals !== e_fv)
                $display("FAIL wrap_out[%0d]: got %h/%b exp %h/%b", n, rq.tags2free, rq.freevals, e_t2f, e_fv); else passed++;
            checks++; if (rq.count > 5'd8) $display("FAIL wrap_count[%0d]: got %0d exp <=8", n, rq.count); else passed++;
        end
        bad = 0;
        for (int i = 0; i < rel.size(); i++) if (rel[i] != 8'(i + 1)) bad++;
        checks++; if (rel.size() != 160 || bad != 0)
            $display("FAIL wrap_order: got %0d tags with %0d misplaced exp 160 in order", rel.size(), bad); else passed++;
    endtask

    task automatic test_flush();
        logic [191:0] fl;
        fl = '0; fl[5] = 1'b1; fl[190] = 1'b1;
        m_v = 4'hf; m_tags = 32'h0d0c_0b0a;
        tick();
        m_v = 4'h3; m_tags = 32'h0000_0f0e; m_fv = 1'b1; m_fl = fl;
        tick();
        checks++; if (rq.list2free !== fl) $display("FAIL flush_list: got %h exp %h", rq.list2free, fl); else passed++;
        checks++; if (rq.tags2free !== 32'h0d0c_0b0a || rq.freevals !== 4'hf)
            $display("FAIL flush_drain: got %h/%b exp 0d0c0b0a/1111", rq.tags2free, rq.freevals); else passed++;
        tick();
        checks++; if (rq.list2free !== 192'd0) $display("FAIL flush_clear: got %h exp 0", rq.list2free); else passed++;
        checks++; if (rq.tags2free !== 32'h0000_0f0e || rq.freevals !== 4'b0011)
            $display("FAIL flush_after: got %h/%b exp 00000f0e/0011", rq.tags2free, rq.freevals); else passed++;
    endtask

    task automatic test_backpressure();
        for (int n = 0; n < 14; n++) begin
            if (n < 5) begin
                s_v = 4'hf;
                for (int i = 0; i < 4; i++) s_tags[i*8 +: 8] = 8'(4*n + i + 1);
            end
            tick();
            checks++; if (rs.count !== 4'(sq.size())) $display("FAIL bp_count[%0d]: got %0d exp %0d", n, rs.count, sq.size()); else passed++;
            checks++; if (rs.cmt_rdy !== ((8 - sq.size()) >= 4)) $display("FAIL bp_rdy[%0d]: got %b", n, rs.cmt_rdy); else passed++;
            checks++; if (rs.ovf !== s_ovf) $display("FAIL bp_ovf[%0d]: got %b exp %b", n, rs.ovf, s_ovf); else passed++;
            checks++; if (rs.tags2free !== e_s_t2f || rs.freevals !== e_s_fv)
                $display("FAIL bp_out[%0d]: got %h/%b exp %h/%b", n, rs.tags2free, rs.freevals, e_s_t2f, e_s_fv); else passed++;
        end
        checks++; if (rs.ovf !== 1'b1) $display("FAIL bp_ovf_sticky: got %b exp 1", rs.ovf); else passed++;
    endtask

    task automatic test_reset_mid_drain();
        m_v = 4'hf; m_tags = 32'h2423_2221; tick();
        m_v = 4'hf; m_tags = 32'h2827_2625; tick();
        m_v = 4'h1; m_tags = 32'h0000_0029; tick();
        checks++; if (rq.count !== 5'd1) $display("FAIL mid_pre_count: got %0d exp 1", rq.count); else passed++;
        rst_assert();
        checks++; if (rq.count !== 5'd0) $display("FAIL mid_count: got %0d exp 0", rq.count); else passed++;
        checks++; if (rq.freevals !== 4'd0) $display("FAIL mid_fv: got %b exp 0", rq.freevals); else passed++;
        checks++; if (rs.ovf !== 1'b0) $display("FAIL mid_small_ovf: got %b exp 0", rs.ovf); else passed++;
        rst_release();
        for (int n = 0; n < 4; n++) begin
            tick();
            checks++; if (rq.freevals !== 4'd0 || rq.tags2free !== 32'd0)
                $display("FAIL mid_stale[%0d]: got %h/%b exp 0/0", n, rq.tags2free, rq.freevals); else passed++;
        end
    endtask

    initial begin
        drive_idle();
        m_ovf = 1'b0; s_ovf = 1'b0;
        test_reset();
        test_compaction();
        test_random();
        test_wrap();
        test_flush();
        tick(); tick();
        test_backpressure();
        test_reset_mid_drain();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
